// File: rtl/spec_dep_table.sv
// spec_dep_table: speculative branch dependency table with selective kill on mispredict
module spec_dep_table #(
  parameter int NTAG = 5,
  parameter int WAYS = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WAYS-1:0]            alloc_en,
  input  logic [WAYS*NTAG-1:0]       alloc_tag,
  input  logic                       resolve_valid,
  input  logic [NTAG-1:0]            resolve_tag,
  input  logic                       resolve_miss,
  input  logic [NTAG-1:0]            query_tag,
  output logic [NTAG-1:0]            query_mask,
  output logic [NTAG-1:0]            tag_valid,
  output logic [NTAG-1:0]            free_mask,
  output logic [$clog2(NTAG+1)-1:0]  free_cnt,
  output logic                       kill_valid,
  output logic [NTAG-1:0]            kill_mask,
  output logic                       err
);
  localparam int CW = $clog2(NTAG + 1);
  logic [NTAG-1:0] dep   [NTAG];
  logic [NTAG-1:0] dep_n [NTAG];
  logic [NTAG-1:0] kill_set, retired, killed, clr, valid_n, seen, a;
  logic miss, bad;
  assign miss      = resolve_valid & resolve_miss;
  assign free_mask = ~tag_valid;
  always_comb begin
    query_mask = '0;
    kill_set   = '0;
    free_cnt   = '0;
    for (int c = 0; c < NTAG; c++) begin
      query_mask[c] = |(dep[c] & query_tag);
      kill_set[c]   = |(dep[c] & resolve_tag);
      free_cnt      = free_cnt + CW'(free_mask[c]);
    end
  end
  always_comb begin
    retired = (resolve_valid & ~resolve_miss) ? resolve_tag : '0;
    killed  = miss ? kill_set : '0;
    clr     = retired | killed;
    valid_n = tag_valid & ~clr;
    seen    = '0;
    a       = '0;
    bad     = resolve_valid && (!$onehot(resolve_tag) || |(resolve_tag & ~tag_valid));
    for (int r = 0; r < NTAG; r++)
      dep_n[r] = clr[r] ? '0 : dep[r] & ~clr;
    for (int w = 0; w < WAYS; w++) begin
      a = alloc_tag[w*NTAG +: NTAG];
      if (alloc_en[w]) begin
        bad = bad || !$onehot(a) || |(a & (tag_valid | seen));
        if (!miss) begin
          for (int r = 0; r < NTAG; r++)
            if (a[r]) dep_n[r] = a | valid_n;
          valid_n = valid_n | a;
        end
        seen = seen | a;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_valid  <= '0;
      kill_valid <= 1'b0;
      kill_mask  <= '0;
      err        <= 1'b0;
      for (int r = 0; r < NTAG; r++) dep[r] <= '0;
    end else begin
      tag_valid  <= valid_n;
      kill_valid <= miss;
      kill_mask  <= killed;
      err        <= err | bad;
      for (int r = 0; r < NTAG; r++) dep[r] <= dep_n[r];
    end
  end
endmodule

// File: tb/tb_spec_dep_table.sv
// tb_spec_dep_table: scoreboard bench for spec_dep_table with directed vectors
module tb_spec_dep_table;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] alloc_en = '0;
  logic [9:0] alloc_tag = '0;
  logic       resolve_valid = 1'b0;
  logic [4:0] resolve_tag = '0;
  logic       resolve_miss = 1'b0;
  logic [4:0] query_tag = '0;
  logic [4:0] query_mask, tag_valid, free_mask, kill_mask;
  logic [2:0] free_cnt;
  logic       kill_valid, err;
  int checks = 0;
  int errors = 0;
  typedef struct {
    int         kind;
    logic [4:0] arg;
    logic [4:0] exp;
  } chk_t;
  chk_t       chk_q[$];
  logic [4:0] kill_q[$];
  spec_dep_table #(.NTAG(5), .WAYS(2)) dut (
    .clk(clk), .reset(reset), .alloc_en(alloc_en), .alloc_tag(alloc_tag),
    .resolve_valid(resolve_valid), .resolve_tag(resolve_tag), .resolve_miss(resolve_miss),
    .query_tag(query_tag), .query_mask(query_mask), .tag_valid(tag_valid),
    .free_mask(free_mask), .free_cnt(free_cnt), .kill_valid(kill_valid),
    .kill_mask(kill_mask), .err(err)
  );
  always #5 clk = ~clk;
  function automatic string kname(int k);
    case (k)
      0: return "tag_valid";
      1: return "free_cnt";
      2: return "err";
      3: return "kill_valid";
      4: return "query_mask";
      5: return "free_mask";
      default: return "kill_queue_left";
    endcase
  endfunction
  initial begin
    forever begin
      @(negedge clk);
      while (chk_q.size() != 0) begin
        chk_t c;
        logic [4:0] got;
        c = chk_q.pop_front();
        got = c.kind == 0 ? tag_valid :
              c.kind == 1 ? 5'(free_cnt) :
              c.kind == 2 ? {4'b0, err} :
              c.kind == 3 ? {4'b0, kill_valid} :
              c.kind == 4 ? query_mask :
              c.kind == 5 ? free_mask : 5'(kill_q.size());
        checks++;
        if (got !== c.exp) begin
          errors++;
          $display("FAIL %s (query %b) got %b expected %b", kname(c.kind), c.arg, got, c.exp);
        end
      end
      if (kill_valid === 1'b1) begin
        checks++;
        if (kill_q.size() == 0) begin
          errors++;
          $display("FAIL kill_mask unexpected pulse got %b expected no pulse", kill_mask);
        end else begin
          logic [4:0] e;
          e = kill_q.pop_front();
          if (kill_mask !== e) begin
            errors++;
            $display("FAIL kill_mask got %b expected %b", kill_mask, e);
          end
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
    reset = 1'b0;
    alloc_en = '0;
    alloc_tag = '0;
    resolve_valid = 1'b0;
    resolve_miss = 1'b0;
    resolve_tag = '0;
  endtask
  task automatic chk(int kind, logic [4:0] exp);
    chk_q.push_back('{kind, 5'b0, exp});
  endtask
  task automatic q(logic [4:0] tag, logic [4:0] exp);
    query_tag = tag;
    chk_q.push_back('{4, tag, exp});
    @(negedge clk);
    #1;
  endtask
  task automatic alloc(logic [1:0] en, logic [4:0] t0, logic [4:0] t1);
    alloc_en = en;
    alloc_tag = {t1, t0};
  endtask
  task automatic resolve(logic miss, logic [4:0] t);
    resolve_valid = 1'b1;
    resolve_miss = miss;
    resolve_tag = t;
    if (miss) kill_q.push_back(5'b0);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tick();
  endtask
  initial begin
    do_reset();
    chk(0, 5'b00000); chk(1, 5'd5); chk(3, 5'd0); chk(2, 5'd0); chk(5, 5'b11111);
    q(5'b00001, 5'b00000);
    alloc(2'b11, 5'b00001, 5'b00010); tick();
    alloc(2'b01, 5'b00100, 5'b0); tick();
    chk(0, 5'b00111); chk(1, 5'd2);
    q(5'b00001, 5'b00111);
    q(5'b00010, 5'b00110);
    q(5'b00100, 5'b00100);
    resolve(1'b1, 5'b00010); kill_q[kill_q.size()-1] = 5'b00110; tick();
    chk(3, 5'd1); chk(0, 5'b00001); chk(2, 5'd0);
    q(5'b00001, 5'b00001);
    chk(3, 5'd0);
    q(5'b00010, 5'b00000);
    do_reset();
    alloc(2'b11, 5'b00001, 5'b00010); tick();
    resolve(1'b0, 5'b00001); alloc(2'b01, 5'b01000, 5'b0); tick();
    chk(0, 5'b01010); chk(2, 5'd0);
    q(5'b00010, 5'b01010);
    q(5'b01000, 5'b01000);
    q(5'b00001, 5'b00000);
    do_reset();
    alloc(2'b01, 5'b00001, 5'b0); tick();
    resolve(1'b1, 5'b00001); kill_q[kill_q.size()-1] = 5'b00001;
    alloc(2'b01, 5'b00010, 5'b0); tick();
    chk(0, 5'b00000); chk(2, 5'd0); chk(3, 5'd1);
    q(5'b00001, 5'b00000);
    do_reset();
    alloc(2'b11, 5'b00001, 5'b00010); tick();
    alloc(2'b01, 5'b00100, 5'b0); tick();
    resolve(1'b1, 5'b00100); kill_q[kill_q.size()-1] = 5'b00100; tick();
    resolve(1'b1, 5'b00010); kill_q[kill_q.size()-1] = 5'b00010; tick();
    chk(0, 5'b00001); chk(3, 5'd1);
    q(5'b00001, 5'b00001);
    do_reset();
    alloc(2'b01, 5'b00001, 5'b0); tick();
    chk(2, 5'd0);
    q(5'b00001, 5'b00001);
    alloc(2'b01, 5'b00001, 5'b0); tick();
    chk(2, 5'd1);
    q(5'b0, 5'b0);
    tick();
    chk(2, 5'd1);
    q(5'b0, 5'b0);
    do_reset();
    chk(2, 5'd0);
    q(5'b0, 5'b0);
    resolve(1'b0, 5'b10000); tick();
    chk(2, 5'd1);
    q(5'b0, 5'b0);
    do_reset();
    alloc(2'b11, 5'b00010, 5'b00010); tick();
    chk(2, 5'd1);
    q(5'b0, 5'b0);
    do_reset();
    alloc(2'b01, 5'b00011, 5'b0); tick();
    chk(2, 5'd1);
    q(5'b0, 5'b0);
    do_reset();
    alloc(2'b11, 5'b00001, 5'b00010); tick();
    alloc(2'b11, 5'b00100, 5'b01000); tick();
    alloc(2'b01, 5'b10000, 5'b0); tick();
    chk(1, 5'd0); chk(0, 5'b11111); chk(5, 5'b00000); chk(2, 5'd0);
    q(5'b00001, 5'b11111);
    q(5'b10000, 5'b10000);
    q(5'b01000, 5'b11000);
    alloc(2'b01, 5'b00100, 5'b0); tick();
    chk(2, 5'd1);
    q(5'b0, 5'b0);
    reset = 1'b1;
    resolve_valid = 1'b1; resolve_miss = 1'b1; resolve_tag = 5'b00001;
    tick();
    chk(0, 5'b00000); chk(1, 5'd5); chk(3, 5'd0); chk(2, 5'd0); chk(5, 5'b11111);
    q(5'b00001, 5'b00000);
    tick();
    chk(6, 5'd0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
